// File: rtl/context_switch_controller.sv
// -----------------------------------------------------------------------------
// context_switch_controller
//
// Preemption and I/O context controller placed in front of the CPU PC mux.
// It counts a time quantum for the running process and saves that process's
// PC into a four-entry table. It then redirects the CPU to the scheduler, or
// to the I/O routine, and finally hands back the resume PC of the process the
// scheduler picked.
//
// Every redirect output is registered one cycle behind the state that
// produces it. PREEMPT/IOSW/RESUME each emit their code on the edge that
// leaves the state, so the CPU sees the code for one cycle after that edge.
//
// Parameters
//   QUANTUM             unhalted RUN cycles per time slice (1..65535)
//
// Ports
//   clock               system clock, rising edge
//   reset               synchronous, active-high
//   enable              preemption enabled; low sends RUN back to IDLE
//   halt                CPU stalled; freezes the quantum counter
//   pc[31:0]            current CPU PC
//   io_request          CPU is executing an I/O instruction
//   botaoIN             one-cycle I/O completion pulse
//   sched_done          one-cycle pulse, scheduler chose next_proc
//   next_proc[1:0]      process id chosen by the scheduler
//   troca_contexto[1:0] 00 none, 11 jump to scheduler, 01 load resume_pc
//   intrucaoIOContexto  jump to the I/O routine
//   resume_pc[31:0]     PC to load while troca_contexto == 01
//   cur_proc[1:0]       id of the running process
//   blocked[3:0]        per-process I/O-blocked mask
//   sched_err           sticky: scheduler picked a blocked process
// -----------------------------------------------------------------------------
module context_switch_controller #(
  parameter int unsigned QUANTUM = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        halt,
  input  logic [31:0] pc,
  input  logic        io_request,
  input  logic        botaoIN,
  input  logic        sched_done,
  input  logic [1:0]  next_proc,
  output logic [1:0]  troca_contexto,
  output logic        intrucaoIOContexto,
  output logic [31:0] resume_pc,
  output logic [1:0]  cur_proc,
  output logic [3:0]  blocked,
  output logic        sched_err
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PREEMPT,
    IOSW,
    SCHED,
    RESUME
  } state_t;

  localparam logic [15:0] QLOAD = 16'(QUANTUM - 1);

  state_t      state;
  logic [15:0] counter;
  logic [1:0]  ioOwner;
  logic [31:0] pcTable [4];

  logic        ioCapture;
  logic [3:0]  blockedNext;

  // An I/O capture only happens in RUN while enabled. Disabling has priority.
  assign ioCapture = (state == RUN) && enable && io_request;

  // The completion pulse clears the owner's bit first. A capture in the same
  // cycle then sets its bit, so a set always wins over a simultaneous clear.
  always_comb begin
    blockedNext = blocked;
    if (botaoIN) begin
      blockedNext[ioOwner] = 1'b0;
    end
    if (ioCapture) begin
      blockedNext[cur_proc] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      counter            <= '0;
      ioOwner            <= '0;
      troca_contexto     <= 2'b00;
      intrucaoIOContexto <= 1'b0;
      resume_pc          <= '0;
      cur_proc           <= '0;
      blocked            <= '0;
      sched_err          <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pcTable[i] <= '0;
      end
    end else begin
      // Redirect codes are single-cycle pulses. Default them low here, and
      // only the states below re-assert one.
      troca_contexto     <= 2'b00;
      intrucaoIOContexto <= 1'b0;
      blocked            <= blockedNext;

      case (state)
        IDLE: begin
          if (enable) begin
            state   <= RUN;
            counter <= QLOAD;
          end
        end

        RUN: begin
          if (!enable) begin
            state <= IDLE;
          end else if (io_request) begin
            // Resume after the I/O instruction. The PC wraps at 2^32.
            // io_request is honoured even while halted.
            pcTable[cur_proc] <= pc + 32'd1;
            ioOwner           <= cur_proc;
            state             <= IOSW;
          end else if (!halt) begin
            if (counter == 16'd0) begin
              pcTable[cur_proc] <= pc;
              state             <= PREEMPT;
            end else begin
              counter <= counter - 16'd1;
            end
          end
        end

        PREEMPT: begin
          troca_contexto <= 2'b11;
          state          <= SCHED;
        end

        IOSW: begin
          troca_contexto     <= 2'b11;
          intrucaoIOContexto <= 1'b1;
          state              <= SCHED;
        end

        SCHED: begin
          if (sched_done) begin
            // Use the registered mask. A botaoIN in this same cycle does not
            // yet unblock the chosen process.
            if (blocked[next_proc]) begin
              sched_err <= 1'b1;
            end else begin
              cur_proc  <= next_proc;
              resume_pc <= pcTable[next_proc];
              state     <= RESUME;
            end
          end
        end

        RESUME: begin
          troca_contexto <= 2'b01;
          counter        <= QLOAD;
          state          <= RUN;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/context_switch_controller.md
# context_switch_controller

Preemption and I/O context controller that sits directly upstream of the CPU program-counter mux. It counts a time quantum for the running process, saves that process's PC into a four-entry table, and drives `troca_contexto` / `intrucaoIOContexto` to redirect the CPU to the scheduler or the I/O routine. It then hands the CPU the resume PC of whichever process the scheduler selects.

## Interface
- `QUANTUM`, default 100: unhalted RUN cycles per time slice; legal range 1..65535.
- `clock`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; takes effect on the next rising edge of `clock`.
- `enable`  in  1: preemption enabled (written by the OS); 0 forces IDLE.
- `halt`  in  1: CPU stalled (`parada`); freezes the quantum counter.
- `pc`  in  32: current CPU PC.
- `io_request`  in  1: CPU is executing an I/O instruction (`entradaSaidaControl != 0`).
- `botaoIN`  in  1: one-cycle I/O completion pulse.
- `sched_done`  in  1: one-cycle pulse; the scheduler has chosen `next_proc`.
- `next_proc`  in  2: process id selected by the scheduler.
- `troca_contexto`  out  2: 2'b00 none, 2'b11 jump to scheduler, 2'b01 load `resume_pc`.
- `intrucaoIOContexto`  out  1: jump to the I/O routine.
- `resume_pc`  out  32: PC to load when `troca_contexto == 2'b01`.
- `cur_proc`  out  2: id of the running process.
- `blocked`  out  4: per-process I/O-blocked mask.
- `sched_err`  out  1: sticky; `sched_done` selected a blocked process.

## Operation
- States: IDLE, RUN, PREEMPT, IOSW, SCHED, RESUME.
- Every output is registered.
- Reset values:
  - state = IDLE.
  - `troca_contexto` = 0, `intrucaoIOContexto` = 0.
  - `resume_pc` = 0, `cur_proc` = 0, `blocked` = 0, `sched_err` = 0.
  - PC table all 0, `io_owner` = 0, counter = 0.
- IDLE:
  - `enable == 1` → RUN; counter loaded with QUANTUM-1.
- RUN, conditions checked in this priority order:
  - `enable == 0` → IDLE. The PC table and `blocked` are retained.
  - `io_request` (evaluated even when `halt`):
    - table[`cur_proc`] ← `pc`+1, wrapping mod 2^32.
    - `blocked[cur_proc]` ← 1, `io_owner` ← `cur_proc`.
    - Next state IOSW.
  - `!halt && counter == 0`:
    - table[`cur_proc`] ← `pc`.
    - Next state PREEMPT.
  - `!halt`: counter decrements by 1.
  - `halt` with no `io_request`: counter holds.
- PREEMPT: `troca_contexto` = 2'b11 for exactly one cycle → SCHED.
- IOSW: `intrucaoIOContexto` = 1 and `troca_contexto` = 2'b11 for exactly one cycle → SCHED.
- SCHED: outputs 0; waits for `sched_done`.
  - If `blocked[next_proc] == 1`: set `sched_err`, remain in SCHED.
  - Otherwise: `cur_proc` ← `next_proc`, `resume_pc` ← table[`next_proc`] → RESUME.
- RESUME: `troca_contexto` = 2'b01 for one cycle; counter ← QUANTUM-1 → RUN.
- `botaoIN` (any state): `blocked[io_owner]` ← 0.
  - If this coincides with the `io_request` capture that sets `blocked`, the set wins.
- `sched_done` outside SCHED is ignored.
- `io_request` outside RUN is ignored; the CPU is being redirected.
- `sched_err` clears only on reset.
- Only one redirect code is active in any cycle.

## Timing
- Preemption:
  - `troca_contexto` = 2'b11 appears exactly QUANTUM unhalted RUN cycles after the RESUME cycle, or after IDLE→RUN.
  - Each halted cycle delays it by one cycle.
- I/O redirect: `io_request` sampled high at edge N in RUN → `intrucaoIOContexto` high during the cycle after edge N+1 (one-cycle latency through IOSW).
- Resume: `sched_done` at edge N → `troca_contexto` = 2'b01 with a valid `resume_pc` after edge N+1.
  - The CPU loads `resume_pc` at edge N+2.
  - Counting restarts at edge N+2.
- Reset mid-operation: the next edge returns everything to the reset values, including during PREEMPT/IOSW pulses.
- The table is written only on RUN exits. `resume_pc` is stable from RESUME until the next `sched_done`.

## Test plan
- QUANTUM=4, `enable`=1, `pc` = 0x40, no halt → `troca_contexto` = 2'b11 for one cycle, 4 cycles after entering RUN. Then `sched_done`, `next_proc` = 1 → `troca_contexto` = 2'b01, `resume_pc` = 0, `cur_proc` = 1.
- QUANTUM=4 with `halt` high for 3 of those cycles → preemption delayed by exactly 3 cycles.
- `io_request` in RUN at `pc` = 0xFFFFFFFF, `cur_proc` = 0 → `intrucaoIOContexto` pulse, table[0] = 0x00000000, `blocked` = 4'b0001. Then `sched_done` with `next_proc` = 0 → `sched_err` = 1, state stays SCHED.
- `botaoIN` after the previous test → `blocked` = 0. A retried `sched_done`, `next_proc` = 0 → `resume_pc` = 0x00000000.
- `io_request` and counter == 0 in the same cycle → only the I/O path is taken: `intrucaoIOContexto` = 1, saved PC = `pc`+1.
- Assert `reset` during the PREEMPT cycle → next edge: all outputs 0, state IDLE, table cleared.
